// File: rtl/modbus_bus_arbiter.sv
// modbus_bus_arbiter: two-master, one-slave round-robin arbiter for the 16-bit MODBUS register bus.
// The grant is held until the slave acks; a watchdog completes hung transfers with ERRDATA.
module modbus_bus_arbiter #(
  parameter int unsigned TMOSIZE = 8,
  parameter logic [15:0] ERRDATA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_iswrite,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic [15:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_valid,
  input  logic        m1_iswrite,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic [15:0] m1_rdata,
  output logic        m1_ack,
  output logic        s_valid,
  output logic        s_iswrite,
  output logic [15:0] s_addr,
  output logic [15:0] s_wdata,
  input  logic [15:0] s_rdata,
  input  logic        s_ack,
  output logic        busy,
  output logic        owner,
  output logic        tmo_err,
  output logic [7:0]  tmo_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [TMOSIZE-1:0] WDOG_MAX = {TMOSIZE{1'b1}};
  localparam logic [TMOSIZE-1:0] WDOG_ONE = {{(TMOSIZE-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               s_valid_q, s_valid_d;
  logic               s_iswrite_q, s_iswrite_d;
  logic [15:0]        s_addr_q, s_addr_d;
  logic [15:0]        s_wdata_q, s_wdata_d;
  logic [15:0]        m0_rdata_q, m0_rdata_d;
  logic [15:0]        m1_rdata_q, m1_rdata_d;
  logic               m0_ack_q, m0_ack_d;
  logic               m1_ack_q, m1_ack_d;
  logic               tmo_err_q, tmo_err_d;
  logic [7:0]         tmo_count_q, tmo_count_d;
  logic [TMOSIZE-1:0] wdog_q, wdog_d;
  logic               busy_q, busy_d;
  logic               gnt_idx;
  logic               sel_valid;

  // Only the granted master's valid is watched while a transfer is open.
  assign sel_valid = owner_q ? m1_valid : m0_valid;

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    s_valid_d   = s_valid_q;
    s_iswrite_d = s_iswrite_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    tmo_err_d   = 1'b0;
    tmo_count_d = tmo_count_q;
    wdog_d      = wdog_q;
    gnt_idx     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m0_valid || m1_valid) begin
          // On contention the master that did not win last time goes first.
          gnt_idx     = (m0_valid && m1_valid) ? ~owner_q : m1_valid;
          owner_d     = gnt_idx;
          s_valid_d   = 1'b1;
          s_iswrite_d = gnt_idx ? m1_iswrite : m0_iswrite;
          s_addr_d    = gnt_idx ? m1_addr : m0_addr;
          s_wdata_d   = gnt_idx ? m1_wdata : m0_wdata;
          wdog_d      = WDOG_MAX;
          state_d     = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (s_ack) begin
          s_valid_d = 1'b0;
          if (owner_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = s_iswrite_q ? m1_rdata_q : s_rdata;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = s_iswrite_q ? m0_rdata_q : s_rdata;
          end
          state_d = S_DONE;
        end else if (wdog_q == '0) begin
          s_valid_d   = 1'b0;
          tmo_err_d   = 1'b1;
          tmo_count_d = (tmo_count_q == 8'hFF) ? tmo_count_q : tmo_count_q + 8'd1;
          if (owner_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = ERRDATA;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = ERRDATA;
          end
          state_d = S_DONE;
        end else if (!sel_valid) begin
          s_valid_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          wdog_d = wdog_q - WDOG_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        s_valid_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops every output immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b1;
      s_valid_q   <= 1'b0;
      s_iswrite_q <= 1'b0;
      s_addr_q    <= 16'h0000;
      s_wdata_q   <= 16'h0000;
      m0_rdata_q  <= 16'h0000;
      m1_rdata_q  <= 16'h0000;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      tmo_err_q   <= 1'b0;
      tmo_count_q <= 8'h00;
      wdog_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      s_valid_q   <= s_valid_d;
      s_iswrite_q <= s_iswrite_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      tmo_err_q   <= tmo_err_d;
      tmo_count_q <= tmo_count_d;
      wdog_q      <= wdog_d;
      busy_q      <= busy_d;
    end
  end

  assign m0_rdata  = m0_rdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_rdata  = m1_rdata_q;
  assign m1_ack    = m1_ack_q;
  assign s_valid   = s_valid_q;
  assign s_iswrite = s_iswrite_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign tmo_err   = tmo_err_q;
  assign tmo_count = tmo_count_q;

endmodule
